tag_cache_wrapper: RTL and testbench

Blocking bridge between one uncached TileLink-style client port and a backing memory port (cmd/data/resp). Every 64-bit data word carries a 4-bit tag. Data goes to memory below TagBase; tags are packed 16 per 64-bit word in a tag partition at TagBase. Tag words are held in a small direct-mapped, write-back tag cache inside the block. The block sits between the random tester / cores and the memory model.

---
 rtl/tag_cache_wrapper_pkg.sv | 62 ++++++
 rtl/tag_cache_wrapper_if.sv | 67 ++++++
 rtl/tag_cache_wrapper_tag_line_array.sv | 68 ++++++
 rtl/tag_cache_wrapper.sv | 212 +++++++++++++++++++++
 tb/tb_tag_cache_wrapper.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tag_cache_wrapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Widths, tag-partition base, FSM state encoding, handshake
//               encodings and address-mapping helpers for tag_cache_wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int TAG_BITS = 4;
    localparam int ID_W     = 2;
    localparam int N_LINES  = 8;
    localparam int SLOT_W   = $clog2(DATA_W / TAG_BITS);
    localparam int IDX_W    = $clog2(N_LINES);
    localparam int LID_W    = ADDR_W - SLOT_W - IDX_W;

    localparam logic [ADDR_W-1:0] TAG_BASE = 32'h0800_0000;

    localparam logic ACQ_GET     = 1'b0;
    localparam logic ACQ_PUT     = 1'b1;
    localparam logic MEM_RD      = 1'b0;
    localparam logic MEM_WR      = 1'b1;
    localparam logic MEM_ID_DATA = 1'b0;
    localparam logic MEM_ID_TAG  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WB        = 3'd1,
        ST_FILL_CMD  = 3'd2,
        ST_FILL_RESP = 3'd3,
        ST_DATA_REQ  = 3'd4,
        ST_DATA_RESP = 3'd5,
        ST_GRANT     = 3'd6
    } state_t;

    // Word address of the tag word holding the tag of data word a.
    function automatic logic [ADDR_W-1:0] tag_addr(input logic [ADDR_W-1:0] a);
        return TAG_BASE + (a >> SLOT_W);
    endfunction

    // Which 4-bit slot inside the tag word belongs to data word a.
    function automatic logic [SLOT_W-1:0] tag_slot(input logic [ADDR_W-1:0] a);
        return a[SLOT_W-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] line_idx(input logic [ADDR_W-1:0] a);
        return a[SLOT_W +: IDX_W];
    endfunction

    function automatic logic [LID_W-1:0] line_id(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 : SLOT_W + IDX_W];
    endfunction

    function automatic logic [TAG_BITS-1:0] slot_tag(input logic [DATA_W-1:0] word,
                                                     input logic [SLOT_W-1:0] slot);
        return word[slot * TAG_BITS +: TAG_BITS];
    endfunction

endpackage
`default_nettype wire

// File: rtl/tag_cache_wrapper_if.sv
`default_nettype none
// ============================================================================
// Module      : tag_cache_if
// Description : Client acquire/grant channels and backing-memory
//               cmd/data/resp channels of the tag cache bridge.
//               slave  = the bridge, master = client + memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface tag_cache_if;
    import cache_pkg::*;

    logic                acq_valid;
    logic                acq_ready;
    logic                acq_put;
    logic [ADDR_W-1:0]   acq_addr;
    logic [DATA_W-1:0]   acq_data;
    logic [TAG_BITS-1:0] acq_tag;
    logic [ID_W-1:0]     acq_id;

    logic                gnt_valid;
    logic                gnt_ready;
    logic                gnt_put;
    logic [DATA_W-1:0]   gnt_data;
    logic [TAG_BITS-1:0] gnt_tag;
    logic [ID_W-1:0]     gnt_id;

    logic                mem_cmd_valid;
    logic                mem_cmd_ready;
    logic                mem_cmd_rw;
    logic [ADDR_W-1:0]   mem_cmd_addr;
    logic                mem_cmd_id;
    logic                mem_data_valid;
    logic                mem_data_ready;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_resp_valid;
    logic                mem_resp_ready;
    logic [DATA_W-1:0]   mem_resp_data;
    logic                mem_resp_id;

    modport slave (
        input  acq_valid, acq_put, acq_addr, acq_data, acq_tag, acq_id,
        output acq_ready,
        output gnt_valid, gnt_put, gnt_data, gnt_tag, gnt_id,
        input  gnt_ready,
        output mem_cmd_valid, mem_cmd_rw, mem_cmd_addr, mem_cmd_id,
        input  mem_cmd_ready,
        output mem_data_valid, mem_data,
        input  mem_data_ready,
        input  mem_resp_valid, mem_resp_data, mem_resp_id,
        output mem_resp_ready
    );

    modport master (
        output acq_valid, acq_put, acq_addr, acq_data, acq_tag, acq_id,
        input  acq_ready,
        input  gnt_valid, gnt_put, gnt_data, gnt_tag, gnt_id,
        output gnt_ready,
        input  mem_cmd_valid, mem_cmd_rw, mem_cmd_addr, mem_cmd_id,
        output mem_cmd_ready,
        input  mem_data_valid, mem_data,
        output mem_data_ready,
        output mem_resp_valid, mem_resp_data, mem_resp_id,
        input  mem_resp_ready
    );

endinterface
`default_nettype wire

// File: rtl/tag_cache_wrapper_tag_line_array.sv
`default_nettype none
// ============================================================================
// Module      : tag_line_array
// Description : Direct-mapped tag-cache storage, one tag word per line.
//               Combinational read; synchronous line install and single
//               tag-slot update (which marks the line dirty).
// Revision    : 1.0 - initial release
// ============================================================================
module tag_line_array
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    i_rd_idx,
    output logic                o_rd_valid,
    output logic                o_rd_dirty,
    output logic [LID_W-1:0]    o_rd_lid,
    output logic [DATA_W-1:0]   o_rd_data,
    input  logic                i_inst_en,
    input  logic [IDX_W-1:0]    i_inst_idx,
    input  logic [LID_W-1:0]    i_inst_lid,
    input  logic [DATA_W-1:0]   i_inst_data,
    input  logic                i_slot_en,
    input  logic [IDX_W-1:0]    i_slot_idx,
    input  logic [SLOT_W-1:0]   i_slot,
    input  logic [TAG_BITS-1:0] i_slot_tag
);

    logic [N_LINES-1:0] r_valid;
    logic [N_LINES-1:0] r_dirty;
    logic [LID_W-1:0]   r_lid  [N_LINES];
    logic [DATA_W-1:0]  r_data [N_LINES];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_lid   = r_lid[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

    // Line state: reset invalidates everything, an install yields a clean
    // line, a slot write dirties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_inst_en) begin
                r_valid[i_inst_idx] <= 1'b1;
                r_dirty[i_inst_idx] <= 1'b0;
            end
            if (i_slot_en) begin
                r_dirty[i_slot_idx] <= 1'b1;
            end
        end
    end

    // Line payload: contents are don't-care while the line is invalid.
    always_ff @(posedge clk) begin
        if (i_inst_en) begin
            r_lid[i_inst_idx]  <= i_inst_lid;
            r_data[i_inst_idx] <= i_inst_data;
        end
        if (i_slot_en) begin
            r_data[i_slot_idx][i_slot * TAG_BITS +: TAG_BITS] <= i_slot_tag;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tag_cache_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tag_cache_wrapper
// Description : Blocking client-to-memory bridge adding a 4-bit tag per data
//               word. Tags live packed in a partition at TAG_BASE and are
//               cached in a small direct-mapped write-back tag cache.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_cache_wrapper
    import cache_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    tag_cache_if.slave bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_put;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [TAG_BITS-1:0] r_tag;
    logic [ID_W-1:0]     r_id;
    logic                r_cmd_done;
    logic                r_dat_done;
    logic [DATA_W-1:0]   r_gnt_data;
    logic [TAG_BITS-1:0] r_gnt_tag;

    logic                w_line_valid;
    logic                w_line_dirty;
    logic [LID_W-1:0]    w_line_lid;
    logic [DATA_W-1:0]   w_line_data;
    logic [ADDR_W-1:0]   w_look_addr;
    logic                w_hit;
    logic [ADDR_W-1:0]   w_victim_addr;

    logic                w_acq_ready;
    logic                w_gnt_valid;
    logic                w_cmd_valid;
    logic                w_cmd_rw;
    logic                w_cmd_id;
    logic [ADDR_W-1:0]   w_cmd_addr;
    logic                w_dat_valid;
    logic [DATA_W-1:0]   w_dat;
    logic                w_resp_ready;
    logic                w_inst_en;
    logic                w_slot_en;

    logic                w_acq_fire;
    logic                w_cmd_ok;
    logic                w_dat_ok;
    logic                w_resp_tag;
    logic                w_resp_data;

    // In IDLE the lookup must use the incoming address so the hit/victim
    // decision is made in the same cycle the acquire is accepted.
    assign w_look_addr   = (r_state == ST_IDLE) ? bus.acq_addr : r_addr;
    assign w_hit         = w_line_valid && (w_line_lid == line_id(w_look_addr));
    assign w_victim_addr = TAG_BASE + ADDR_W'({w_line_lid, line_idx(r_addr)});

    assign w_acq_fire  = bus.acq_valid && w_acq_ready;
    assign w_cmd_ok    = r_cmd_done || (w_cmd_valid && bus.mem_cmd_ready);
    assign w_dat_ok    = r_dat_done || (w_dat_valid && bus.mem_data_ready);
    assign w_resp_tag  = bus.mem_resp_valid && (bus.mem_resp_id == MEM_ID_TAG);
    assign w_resp_data = bus.mem_resp_valid && (bus.mem_resp_id == MEM_ID_DATA);

    tag_line_array u_lines (
        .clk         (clk),
        .rst         (reset),
        .i_rd_idx    (line_idx(w_look_addr)),
        .o_rd_valid  (w_line_valid),
        .o_rd_dirty  (w_line_dirty),
        .o_rd_lid    (w_line_lid),
        .o_rd_data   (w_line_data),
        .i_inst_en   (w_inst_en),
        .i_inst_idx  (line_idx(r_addr)),
        .i_inst_lid  (line_id(r_addr)),
        .i_inst_data (bus.mem_resp_data),
        .i_slot_en   (w_slot_en),
        .i_slot_idx  (line_idx(r_addr)),
        .i_slot      (tag_slot(r_addr)),
        .i_slot_tag  (r_tag)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and channel outputs; write channels with separate cmd/data
    // handshakes leave only once both halves have transferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_acq_ready  = 1'b0;
        w_gnt_valid  = 1'b0;
        w_cmd_valid  = 1'b0;
        w_cmd_rw     = MEM_RD;
        w_cmd_id     = MEM_ID_DATA;
        w_cmd_addr   = '0;
        w_dat_valid  = 1'b0;
        w_dat        = '0;
        w_resp_ready = 1'b0;
        w_inst_en    = 1'b0;
        w_slot_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_acq_ready = 1'b1;
                if (bus.acq_valid) begin
                    if (bus.acq_addr >= TAG_BASE)          w_state_nxt = ST_GRANT;
                    else if (w_hit)                        w_state_nxt = ST_DATA_REQ;
                    else if (w_line_valid && w_line_dirty) w_state_nxt = ST_WB;
                    else                                   w_state_nxt = ST_FILL_CMD;
                end
            end
            ST_WB: begin
                w_cmd_valid = !r_cmd_done;
                w_cmd_rw    = MEM_WR;
                w_cmd_id    = MEM_ID_TAG;
                w_cmd_addr  = w_victim_addr;
                w_dat_valid = !r_dat_done;
                w_dat       = w_line_data;
                if (w_cmd_ok && w_dat_ok) w_state_nxt = ST_FILL_CMD;
            end
            ST_FILL_CMD: begin
                w_cmd_valid = 1'b1;
                w_cmd_id    = MEM_ID_TAG;
                w_cmd_addr  = tag_addr(r_addr);
                if (bus.mem_cmd_ready) w_state_nxt = ST_FILL_RESP;
            end
            ST_FILL_RESP: begin
                w_resp_ready = 1'b1;
                if (w_resp_tag) begin
                    w_inst_en   = 1'b1;
                    w_state_nxt = ST_DATA_REQ;
                end
            end
            ST_DATA_REQ: begin
                w_cmd_valid = !r_cmd_done;
                w_cmd_id    = MEM_ID_DATA;
                w_cmd_addr  = r_addr;
                if (r_put == ACQ_PUT) begin
                    w_cmd_rw    = MEM_WR;
                    w_dat_valid = !r_dat_done;
                    w_dat       = r_data;
                    if (w_cmd_ok && w_dat_ok) begin
                        w_slot_en   = 1'b1;
                        w_state_nxt = ST_GRANT;
                    end
                end else if (bus.mem_cmd_ready) begin
                    w_state_nxt = ST_DATA_RESP;
                end
            end
            ST_DATA_RESP: begin
                w_resp_ready = 1'b1;
                if (w_resp_data) w_state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                w_gnt_valid = 1'b1;
                if (bus.gnt_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Transaction fields, half-done write flags and grant payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_put      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_tag      <= '0;
            r_id       <= '0;
            r_cmd_done <= 1'b0;
            r_dat_done <= 1'b0;
            r_gnt_data <= '0;
            r_gnt_tag  <= '0;
        end else begin
            r_cmd_done <= (w_state_nxt == r_state) && w_cmd_ok;
            r_dat_done <= (w_state_nxt == r_state) && w_dat_ok;
            if (w_acq_fire) begin
                r_put      <= bus.acq_put;
                r_addr     <= bus.acq_addr;
                r_data     <= bus.acq_data;
                r_tag      <= bus.acq_tag;
                r_id       <= bus.acq_id;
                r_gnt_data <= '0;
                r_gnt_tag  <= '0;
            end
            if ((r_state == ST_DATA_RESP) && w_resp_data) begin
                r_gnt_data <= bus.mem_resp_data;
                r_gnt_tag  <= slot_tag(w_line_data, tag_slot(r_addr));
            end
        end
    end

    assign bus.acq_ready      = w_acq_ready;
    assign bus.gnt_valid      = w_gnt_valid;
    assign bus.gnt_put        = r_put;
    assign bus.gnt_data       = r_gnt_data;
    assign bus.gnt_tag        = r_gnt_tag;
    assign bus.gnt_id         = r_id;
    assign bus.mem_cmd_valid  = w_cmd_valid;
    assign bus.mem_cmd_rw     = w_cmd_rw;
    assign bus.mem_cmd_addr   = w_cmd_addr;
    assign bus.mem_cmd_id     = w_cmd_id;
    assign bus.mem_data_valid = w_dat_valid;
    assign bus.mem_data       = w_dat;
    assign bus.mem_resp_ready = w_resp_ready;

endmodule
`default_nettype wire

// File: tb/tb_tag_cache_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_cache_wrapper
// Description : Scoreboard bench for tag_cache_wrapper: directed scenarios
//               plus random Get/Put traffic against a flat per-word
//               data/tag reference model and a randomly stalling memory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tag_cache_wrapper;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    tag_cache_if bus();

    tag_cache_wrapper dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                put;
        logic [DATA_W-1:0]   data;
        logic [TAG_BITS-1:0] tag;
        logic [ID_W-1:0]     id;
    } gnt_t;

    int n_cmp  = 0;
    int n_fail = 0;
    gnt_t sb[$];

    // Reference model: one value and one tag per data word.
    logic [DATA_W-1:0]   ref_data [logic [31:0]];
    logic [TAG_BITS-1:0] ref_tag  [logic [31:0]];

    // Backing memory model and its traffic statistics.
    logic [DATA_W-1:0] mem [logic [31:0]];
    int rd_cnt [logic [32:0]];
    int wr_cnt [logic [32:0]];
    int n_cmd_total = 0;
    int n_dat_total = 0;
    logic cmd_hold = 1'b0, dat_hold = 1'b0, resp_hold = 1'b0, gnt_hold = 1'b0;
    logic [31:0] wq_addr[$];
    logic [63:0] wq_data[$];
    logic [64:0] rq[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rd_count(input logic id, input logic [31:0] a);
        logic [32:0] k = {id, a};
        return rd_cnt.exists(k) ? rd_cnt[k] : 0;
    endfunction

    function automatic int wr_count(input logic id, input logic [31:0] a);
        logic [32:0] k = {id, a};
        return wr_cnt.exists(k) ? wr_cnt[k] : 0;
    endfunction

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    // Memory model: observe transfers at negedge, drive new ready/resp after posedge.
    initial begin
        logic [32:0] key;
        bus.mem_cmd_ready  = 1'b0;
        bus.mem_data_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_id    = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wq_addr.delete();
                wq_data.delete();
                rq.delete();
            end else begin
                if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
                    n_cmd_total++;
                    key = {bus.mem_cmd_id, bus.mem_cmd_addr};
                    if (bus.mem_cmd_rw) begin
                        wr_cnt[key] = wr_count(bus.mem_cmd_id, bus.mem_cmd_addr) + 1;
                        wq_addr.push_back(bus.mem_cmd_addr);
                    end else begin
                        rd_cnt[key] = rd_count(bus.mem_cmd_id, bus.mem_cmd_addr) + 1;
                        rq.push_back({bus.mem_cmd_id, mem_rd(bus.mem_cmd_addr)});
                    end
                end
                if (bus.mem_data_valid && bus.mem_data_ready) begin
                    n_dat_total++;
                    wq_data.push_back(bus.mem_data);
                end
                if (bus.mem_resp_valid && bus.mem_resp_ready) void'(rq.pop_front());
                while (wq_addr.size() > 0 && wq_data.size() > 0)
                    mem[wq_addr.pop_front()] = wq_data.pop_front();
            end
            @(posedge clk);
            #1;
            bus.mem_cmd_ready  = !cmd_hold && ($urandom_range(0, 3) != 0);
            bus.mem_data_ready = !dat_hold && ($urandom_range(0, 3) != 0);
            if (rq.size() > 0 && !resp_hold && ($urandom_range(0, 2) != 0)) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_id    = rq[0][64];
                bus.mem_resp_data  = rq[0][63:0];
            end else begin
                bus.mem_resp_valid = 1'b0;
                bus.mem_resp_id    = 1'b0;
                bus.mem_resp_data  = '0;
            end
        end
    end

    // Grant back-pressure.
    initial begin
        bus.gnt_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.gnt_ready = !gnt_hold && ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every accepted grant is compared with the oldest expectation.
    initial begin
        gnt_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.gnt_valid && bus.gnt_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got id %0h expected none", bus.gnt_id);
                end else begin
                    e = sb.pop_front();
                    check("gnt_put",  128'(bus.gnt_put),  128'(e.put));
                    check("gnt_data", 128'(bus.gnt_data), 128'(e.data));
                    check("gnt_tag",  128'(bus.gnt_tag),  128'(e.tag));
                    check("gnt_id",   128'(bus.gnt_id),   128'(e.id));
                end
            end
        end
    end

    // Issue one acquire; expectation derives from the flat reference model.
    task automatic issue(input logic put, input logic [31:0] a,
                         input logic [63:0] d, input logic [3:0] t);
        gnt_t e;
        int n;
        e.put = put;
        e.id  = 2'($urandom);
        if (put || a >= TAG_BASE) begin
            e.data = '0;
            e.tag  = '0;
        end else begin
            e.data = ref_data.exists(a) ? ref_data[a] : 64'd0;
            e.tag  = ref_tag.exists(a)  ? ref_tag[a]  : 4'd0;
        end
        if (put && a < TAG_BASE) begin
            ref_data[a] = d;
            ref_tag[a]  = t;
        end
        sb.push_back(e);
        bus.acq_valid = 1'b1;
        bus.acq_put   = put;
        bus.acq_addr  = a;
        bus.acq_data  = d;
        bus.acq_tag   = t;
        bus.acq_id    = e.id;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.acq_ready) break;
            n++;
            if (n > 300) break;
        end
        if (n > 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL acq_timeout: got no acq_ready expected ready for addr %0h", a);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        bus.acq_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d pending grants expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = TAG_BASE + 32'($urandom_range(0, 40));
                1:       a = TAG_BASE - 32'($urandom_range(1, 32));
                2:       a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: a = 32'(($urandom_range(0, 3) << 7) | $urandom_range(0, 127));
            endcase
            issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 4'($urandom));
        end
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got no completion expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        int c0, d0;
        logic [127:0] snap;
        bus.acq_valid = 1'b0;
        bus.acq_put   = 1'b0;
        bus.acq_addr  = '0;
        bus.acq_data  = '0;
        bus.acq_tag   = '0;
        bus.acq_id    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_acq_ready", 128'(bus.acq_ready),      128'(1));
        check("rst_gnt_valid", 128'(bus.gnt_valid),      128'(0));
        check("rst_cmd_valid", 128'(bus.mem_cmd_valid),  128'(0));
        check("rst_dat_valid", 128'(bus.mem_data_valid), 128'(0));
        check("rst_resp_rdy",  128'(bus.mem_resp_ready), 128'(0));

        // Put then Get of 0x10: a single tag fill.
        issue(ACQ_PUT, 32'h10, 64'hDEAD_BEEF_0000_0001, 4'h5);
        issue(ACQ_GET, 32'h10, 64'd0, 4'h0);
        wait_idle();
        check("fill_0x10", 128'(rd_count(1'b1, 32'h0800_0001)), 128'(1));

        // Cold Get of 0x20.
        issue(ACQ_GET, 32'h20, 64'd0, 4'h0);
        wait_idle();
        check("fill_0x20", 128'(rd_count(1'b1, 32'h0800_0002)), 128'(1));
        check("read_0x20", 128'(rd_count(1'b0, 32'h20)),        128'(1));

        // Conflict on line 0 forces a write-back of tag 3.
        issue(ACQ_PUT, 32'h0,  64'h1111, 4'h3);
        issue(ACQ_PUT, 32'h80, 64'h2222, 4'h1);
        wait_idle();
        check("wb_count", 128'(wr_count(1'b1, 32'h0800_0000)), 128'(1));
        check("wb_data",  128'(mem_rd(32'h0800_0000)),         128'(64'h3));
        check("fill_0x80", 128'(rd_count(1'b1, 32'h0800_0008)), 128'(1));
        issue(ACQ_GET, 32'h0, 64'd0, 4'h0);
        wait_idle();

        // Command ready low 5 cycles, then data ready low 3 more.
        cmd_hold = 1'b1;
        dat_hold = 1'b1;
        @(posedge clk);
        #1;
        c0 = n_cmd_total;
        d0 = n_dat_total;
        issue(ACQ_PUT, 32'h11, 64'h0123_4567_89AB_CDEF, 4'h9);
        repeat (5) @(posedge clk);
        #1;
        check("stall_no_cmd", 128'(n_cmd_total), 128'(c0));
        cmd_hold = 1'b0;
        for (int i = 0; i < 50 && n_cmd_total == c0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("stall_no_dat", 128'(n_dat_total), 128'(d0));
        dat_hold = 1'b0;
        wait_idle();
        check("stall_cmds", 128'(n_cmd_total), 128'(c0 + 1));
        check("stall_dats", 128'(n_dat_total), 128'(d0 + 1));

        // Grant back-pressure: fields stable, no new acquire accepted.
        gnt_hold = 1'b1;
        @(posedge clk);
        #1;
        issue(ACQ_GET, 32'h11, 64'd0, 4'h0);
        for (int i = 0; i < 100 && !bus.gnt_valid; i++) @(negedge clk);
        snap = {bus.gnt_valid, bus.acq_ready, bus.gnt_put, bus.gnt_data, bus.gnt_tag, bus.gnt_id};
        check("gnt_seen", 128'(bus.gnt_valid), 128'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("gnt_stable",
                  {bus.gnt_valid, bus.acq_ready, bus.gnt_put, bus.gnt_data, bus.gnt_tag, bus.gnt_id},
                  snap);
        end
        gnt_hold = 1'b0;
        wait_idle();

        // Tag-partition accesses never reach memory.
        c0 = n_cmd_total;
        issue(ACQ_GET, TAG_BASE, 64'd0, 4'h0);
        issue(ACQ_PUT, TAG_BASE + 32'd3, 64'h55, 4'h7);
        wait_idle();
        check("tagbase_no_cmd", 128'(n_cmd_total), 128'(c0));

        run_random(200);
        wait_idle();

        // Reset while the tag fill response is outstanding.
        resp_hold = 1'b1;
        c0 = rd_count(1'b1, tag_addr(32'h0010_0000));
        issue(ACQ_GET, 32'h0010_0000, 64'd0, 4'h0);
        for (int i = 0; i < 200 && rd_count(1'b1, tag_addr(32'h0010_0000)) == c0; i++)
            @(posedge clk);
        check("abort_fill_seen", 128'(rd_count(1'b1, tag_addr(32'h0010_0000))), 128'(c0 + 1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        reset = 1'b0;
        resp_hold = 1'b0;
        check("abort_acq_ready", 128'(bus.acq_ready), 128'(1));
        check("abort_gnt_valid", 128'(bus.gnt_valid), 128'(0));
        // Cached-only tags are gone: tags now come from the backing partition.
        foreach (ref_tag[k]) begin
            logic [63:0] w;
            w = mem_rd(tag_addr(k));
            ref_tag[k] = w[k[3:0] * 4 +: 4];
        end
        run_random(80);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
